addr_unit: RTL

ADDR_UNIT -- requirements
Module: addr_unit

---
 rtl/addr_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/addr_unit.sv
// +-------------------------------------------------------------------------+
// | addr_unit: low/high address adder, PC and AB registers, page-carry fix  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module addr_unit #(
   parameter int             AW     = 16,
   parameter int             LW     = 8,
   parameter logic [AW-1:0]  PC_RST = 16'hFFFC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rdy,
   input  logic            halt,
   input  logic [LW-1:0]   DB,
   input  logic [LW-1:0]   REG,
   input  logic            cond,
   input  logic            CI,
   input  logic [5:0]      op,
   input  logic            ld_ahl,
   input  logic            ld_pc,
   input  logic            inc_pc,
   input  logic            fix_en,
   output logic [AW-1:0]   ADDR,
   output logic [AW-1:0]   AB,
   output logic [AW-1:0]   PC,
   output logic            CO,
   output logic            pc_co,
   output logic            fix_busy
);

   localparam int HW = AW - LW;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FIX  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ab_q, ab_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [LW-1:0]   ahl_q, ahl_d;

   logic            en;
   logic [LW-1:0]   base;
   logic [LW:0]     sum;
   logic [LW-1:0]   adl;
   logic [HW-1:0]   db_hi;
   logic [HW-1:0]   hsrc;
   logic [AW:0]     p1;

   // DB feeds the high part zero-extended (or truncated if LW exceeds HW)
   if (LW >= HW) begin : g_db_trunc
      assign db_hi = DB[HW-1:0];
   end else begin : g_db_ext
      assign db_hi = {{(HW-LW){1'b0}}, DB};
   end

   assign en = rdy & ~halt & ~reset;

   always_comb begin
      base = '0;
      casez ({cond, op[3:2]})
         3'b?01:  base = pc_q[LW-1:0];
         3'b?10:  base = ahl_q;
         3'b111:  base = DB;
         default: base = '0;
      endcase
   end

   always_comb begin
      sum = '0;
      case (op[1:0])
         2'b00:   sum = {1'b0, REG} + {{LW{1'b0}}, CI};
         2'b01:   sum = {1'b0, base} + {1'b0, REG} + {{LW{1'b0}}, CI};
         2'b10:   sum = {1'b0, base} + {{LW{1'b0}}, CI};
         default: sum = {1'b0, base} + {1'b0, ab_q[LW-1:0]} + {{LW{1'b0}}, CI};
      endcase
   end

   assign {CO, adl} = sum;

   always_comb begin
      hsrc = '0;
      case (op[5:4])
         2'b00:   hsrc = ab_q[AW-1:LW];
         2'b01:   hsrc = pc_q[AW-1:LW];
         2'b10:   hsrc = db_hi;
         default: hsrc = '0;
      endcase
   end

   // FIX replays the previous address with the deferred page carry applied
   always_comb begin
      ADDR = {hsrc, adl};
      if (state_q == FIX)
         ADDR = {ab_q[AW-1:LW] + HW'(1), ab_q[LW-1:0]};
      else if (!fix_en)
         ADDR = {hsrc + HW'(CO), adl};
   end

   assign p1 = {1'b0, ab_q} + {{AW{1'b0}}, inc_pc};

   always_comb begin
      state_d = state_q;
      ab_d    = ab_q;
      pc_d    = pc_q;
      ahl_d   = ahl_q;
      if (en) begin
         ab_d = ADDR;
         if (state_q == IDLE) begin
            if (ld_pc)
               pc_d = p1[AW-1:0];
            if (ld_ahl)
               ahl_d = DB;
            if (fix_en && CO)
               state_d = FIX;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ab_q    <= '0;
         pc_q    <= PC_RST;
         ahl_q   <= '0;
      end else begin
         state_q <= state_d;
         ab_q    <= ab_d;
         pc_q    <= pc_d;
         ahl_q   <= ahl_d;
      end
   end

   assign AB       = ab_q;
   assign PC       = pc_q;
   assign pc_co    = p1[AW];
   assign fix_busy = (state_q == FIX);

endmodule

`default_nettype wire
